// File: rtl/timing_check_monitor_if.sv
// Bundles the timing monitor's checked inputs and violation outputs.
// The monitor connects through the slave modport; a driver or bench connects through master.
interface timing_check_monitor_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic           ref_ev;
  logic [NCH-1:0] data;
  logic [NCH-1:0] cond;
  logic           clr;
  logic [NCH-1:0] viol_setup;
  logic [NCH-1:0] viol_hold;
  logic [NCH-1:0] viol_width;
  logic [NCH-1:0] notifier;
  logic [CW-1:0]  viol_cnt;

  modport master (
    output ref_ev, data, cond, clr,
    input  viol_setup, viol_hold, viol_width, notifier, viol_cnt
  );

  modport slave (
    input  ref_ev, data, cond, clr,
    output viol_setup, viol_hold, viol_width, notifier, viol_cnt
  );
endinterface

// File: rtl/timing_check_monitor.sv
// Per-channel setup/hold/pulse-width checker with notifier and saturating violation count.
// Optional pulse-width check is compiled in with macro TIMING_CHECK_WIDTH_EN.
module timing_check_monitor #(
  parameter int NCH       = 4,
  parameter int CW        = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int WIDTH_CYC = 3
) (
  input logic                  clk,
  input logic                  rst,
  timing_check_monitor_if.slave bus
);
  localparam int HW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] AGE_MAX = '1;

  if (NCH < 1 || NCH > 32 || CW < 1 || CW > 32 || SETUP_CYC < 0 || HOLD_CYC < 0 || WIDTH_CYC < 0)
  begin : g_param_check
    $error("timing_check_monitor: parameter out of range");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  logic [NCH-1:0] d_q, edge_c, arm_c, setup_c, hold_c, width_c, any_c;
  logic [CW-1:0]  age_q [NCH];
  logic [CW-1:0]  age_c [NCH];
  logic [HW-1:0]  hcnt  [NCH];
  state_t         state [NCH];
  logic [6:0]     pop;
  logic [CW+6:0]  cnt_sum;

  // Age is evaluated combinationally so an edge in the ref_ev cycle already reads as 0.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      edge_c[i]  = bus.data[i] ^ d_q[i];
      age_c[i]   = edge_c[i] ? '0 : ((age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + CW'(1));
      arm_c[i]   = bus.ref_ev && bus.cond[i];
      setup_c[i] = arm_c[i] && (32'(age_c[i]) < SETUP_CYC);
      hold_c[i]  = (state[i] == HOLD) && !arm_c[i] && edge_c[i];
    end
  end

  always_comb begin
    any_c = setup_c | hold_c | width_c;
    pop   = '0;
    for (int unsigned i = 0; i < NCH; i++) pop = pop + 7'(any_c[i]);
    cnt_sum = (CW+7)'(bus.viol_cnt) + (CW+7)'(pop);
  end

`ifdef TIMING_CHECK_WIDTH_EN
  logic [CW-1:0] wcnt [NCH];

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      width_c[i] = !bus.data[i] && d_q[i] && (32'(wcnt[i]) < WIDTH_CYC);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.viol_width <= '0;
      for (int unsigned i = 0; i < NCH; i++) wcnt[i] <= '0;
    end else begin
      bus.viol_width <= width_c;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!bus.data[i])
          wcnt[i] <= '0;
        else if (edge_c[i])
          wcnt[i] <= CW'(1);
        else if (wcnt[i] != AGE_MAX)
          wcnt[i] <= wcnt[i] + CW'(1);
      end
    end
  end
`else
  assign width_c        = '0;
  assign bus.viol_width = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q            <= bus.data;
      bus.viol_setup <= '0;
      bus.viol_hold  <= '0;
      bus.notifier   <= '0;
      bus.viol_cnt   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        age_q[i] <= AGE_MAX;
        state[i] <= IDLE;
        hcnt[i]  <= '0;
      end
    end else begin
      d_q            <= bus.data;
      bus.viol_setup <= setup_c;
      bus.viol_hold  <= hold_c;
      if (bus.clr) begin
        bus.notifier <= '0;
        bus.viol_cnt <= '0;
      end else begin
        bus.notifier <= bus.notifier ^ any_c;
        bus.viol_cnt <= (cnt_sum > (CW+7)'(AGE_MAX)) ? AGE_MAX : cnt_sum[CW-1:0];
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        age_q[i] <= age_c[i];
        // A re-arm takes precedence over an edge, so a coincident edge is judged as setup only.
        case (state[i])
          IDLE: begin
            if (arm_c[i] && HOLD_CYC > 0) begin
              state[i] <= HOLD;
              hcnt[i]  <= HW'(HOLD_CYC);
            end
          end
          HOLD: begin
            if (arm_c[i]) begin
              hcnt[i] <= HW'(HOLD_CYC);
            end else if (edge_c[i] || hcnt[i] == HW'(1)) begin
              state[i] <= IDLE;
              hcnt[i]  <= '0;
            end else begin
              hcnt[i] <= hcnt[i] - HW'(1);
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_timing_check_monitor.sv
// Bench for timing_check_monitor: event-time reference model checked every cycle plus directed literal pins.
module tb_timing_check_monitor;
  localparam int NCH   = 4;
  localparam int CW    = 8;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int WIDTH = 3;
  localparam int MAXV  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timing_check_monitor_if #(.NCH(NCH), .CW(CW)) bus ();

  timing_check_monitor #(
    .NCH(NCH), .CW(CW), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .WIDTH_CYC(WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: tracks event times (last edge, hold-window end, last rise) per channel.
  int t_edge [NCH];
  int hold_end [NCH];
  int t_rise [NCH];
  logic [NCH-1:0] prev, m_setup, m_hold, m_width, m_notif;
  int m_cnt = 0;
  int cyc = 0;

  always @(posedge clk) begin
    int n, age, hw;
    logic e, armed;
    cyc++;
    if (!rst) begin
      m_setup = '0; m_hold = '0; m_width = '0; m_notif = '0; m_cnt = 0;
      for (int i = 0; i < NCH; i++) begin
        t_edge[i] = -100000;
        hold_end[i] = -1;
        t_rise[i] = cyc + 1;
      end
    end else begin
      n = 0;
      for (int i = 0; i < NCH; i++) begin
        e = bus.data[i] != prev[i];
        armed = bus.ref_ev && bus.cond[i];
        if (e) t_edge[i] = cyc;
        age = cyc - t_edge[i];
        if (age > MAXV) age = MAXV;
        m_setup[i] = armed && (age < SETUP);
        m_hold[i] = e && !armed && (cyc <= hold_end[i]);
        if (m_hold[i]) hold_end[i] = -1;
        if (armed && HOLD > 0) hold_end[i] = cyc + HOLD;
        m_width[i] = 1'b0;
`ifdef TIMING_CHECK_WIDTH_EN
        if (e && !bus.data[i]) begin
          hw = cyc - t_rise[i];
          if (hw > MAXV) hw = MAXV;
          m_width[i] = hw < WIDTH;
        end
`endif
        if (e && bus.data[i]) t_rise[i] = cyc;
        if (m_setup[i] || m_hold[i] || m_width[i]) begin
          n++;
          m_notif[i] = ~m_notif[i];
        end
      end
      if (bus.clr) begin
        m_cnt = 0;
        m_notif = '0;
      end else begin
        m_cnt = (m_cnt + n > MAXV) ? MAXV : m_cnt + n;
      end
    end
    prev = bus.data;
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_viol_setup", 32'(bus.viol_setup), 32'(m_setup));
    chk("cyc_viol_hold", 32'(bus.viol_hold), 32'(m_hold));
    chk("cyc_viol_width", 32'(bus.viol_width), 32'(m_width));
    chk("cyc_notifier", 32'(bus.notifier), 32'(m_notif));
    chk("cyc_viol_cnt", 32'(bus.viol_cnt), 32'(m_cnt));
  end

  task automatic pin(input string nm, input logic [31:0] model_v, input logic [31:0] dut_v,
                     input logic [31:0] lit);
    chk({nm, "_model"}, model_v, lit);
    chk({nm, "_dut"}, dut_v, lit);
  endtask

  logic [NCH-1:0] dv = '0;

  task automatic step(input logic r, input logic [NCH-1:0] d, input logic [NCH-1:0] c,
                      input logic cl, input logic rs = 1'b1);
    @(negedge clk);
    bus.ref_ev = r; bus.data = d; bus.cond = c; bus.clr = cl; rst = rs;
    dv = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, dv, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.ref_ev = 1'b0; bus.data = '0; bus.cond = '0; bus.clr = 1'b0;
    repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    pin("rst_setup", 32'(m_setup), 32'(bus.viol_setup), 0);
    pin("rst_notifier", 32'(m_notif), 32'(bus.notifier), 0);
    pin("rst_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 0);
    idle(3);

    // Setup violation: edge one sample before ref_ev
    step(1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0001, 1'b0);
    pin("setup_pulse", 32'(m_setup), 32'(bus.viol_setup), 32'h1);
    pin("setup_notifier", 32'(m_notif), 32'(bus.notifier), 32'h1);
    pin("setup_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 1);
    idle(3);

    // Setup boundary: edge exactly SETUP samples before ref_ev is legal
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0001, 1'b0);
    pin("setup_edge_ok", 32'(m_setup), 32'(bus.viol_setup), 0);
    idle(3);

    // Hold violation on ch1, second toggle ignored
    step(1'b1, 4'b0000, 4'b0010, 1'b0);
    idle(1);
    step(1'b0, 4'b0010, 4'b0000, 1'b0);
    pin("hold_pulse", 32'(m_hold), 32'(bus.viol_hold), 32'h2);
    pin("hold_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 2);
    pin("hold_notifier", 32'(m_notif), 32'(bus.notifier), 32'h3);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    pin("hold_once", 32'(m_hold), 32'(bus.viol_hold), 0);
    idle(3);

    // Hold boundary: edge just after the window closes
    step(1'b1, 4'b0000, 4'b0010, 1'b0);
    idle(2);
    step(1'b0, 4'b0010, 4'b0000, 1'b0);
    pin("hold_edge_ok", 32'(m_hold), 32'(bus.viol_hold), 0);
    idle(3);

    // cond=0 gates the check
    step(1'b1, 4'b0110, 4'b0000, 1'b0);
    pin("cond_off_setup", 32'(m_setup), 32'(bus.viol_setup), 0);
    pin("cond_off_notifier", 32'(m_notif), 32'(bus.notifier), 32'h3);
    idle(3);

    // Width: 2-sample pulse then 3-sample pulse on ch3
    step(1'b0, 4'b1110, 4'b0000, 1'b0);
    step(1'b0, 4'b1110, 4'b0000, 1'b0);
    step(1'b0, 4'b0110, 4'b0000, 1'b0);
`ifdef TIMING_CHECK_WIDTH_EN
    pin("width_short", 32'(m_width), 32'(bus.viol_width), 32'h8);
`else
    pin("width_short", 32'(m_width), 32'(bus.viol_width), 0);
`endif
    repeat (3) step(1'b0, 4'b1110, 4'b0000, 1'b0);
    step(1'b0, 4'b0110, 4'b0000, 1'b0);
    pin("width_ok", 32'(m_width), 32'(bus.viol_width), 0);
    idle(3);

    // Saturation
    step(1'b0, dv, 4'b0000, 1'b1);
    pin("clr_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 0);
    for (int k = 0; k < 63; k++) step(1'b1, ~dv, 4'b1111, 1'b0);
    pin("bulk_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 252);
    step(1'b1, dv ^ 4'b0101, 4'b0101, 1'b0);
    pin("cnt_254", 32'(m_cnt), 32'(bus.viol_cnt), 254);
    step(1'b1, dv ^ 4'b0011, 4'b0001, 1'b0);
    pin("sat_setup", 32'(m_setup), 32'(bus.viol_setup), 32'h1);
    pin("sat_hold", 32'(m_hold), 32'(bus.viol_hold), 32'h2);
    pin("sat_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 255);
    step(1'b1, dv ^ 4'b0001, 4'b0001, 1'b0);
    pin("sat_stay", 32'(m_cnt), 32'(bus.viol_cnt), 255);
    step(1'b1, dv ^ 4'b0001, 4'b0001, 1'b1);
    pin("clr_prio_setup", 32'(m_setup), 32'(bus.viol_setup), 32'h1);
    pin("clr_prio_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 0);
    pin("clr_prio_notifier", 32'(m_notif), 32'(bus.notifier), 0);
    idle(3);

    // Reset mid hold window, then a rising toggle and a ref_ev with no post-reset edge
    step(1'b1, dv, 4'b0010, 1'b0);
    step(1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0);
    pin("rst_mid_hold", 32'(m_hold), 32'(bus.viol_hold), 0);
    step(1'b1, 4'b1011, 4'b0100, 1'b0);
    pin("post_rst_hold", 32'(m_hold), 32'(bus.viol_hold), 0);
    pin("post_rst_setup", 32'(m_setup), 32'(bus.viol_setup), 0);
    pin("post_rst_width", 32'(m_width), 32'(bus.viol_width), 0);
    pin("post_rst_notifier", 32'(m_notif), 32'(bus.notifier), 0);
    pin("post_rst_cnt", 32'(m_cnt), 32'(bus.viol_cnt), 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timing_check_monitor.md
TIMING_CHECK_MONITOR -- requirements
Module: timing_check_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent checked channels (1..32).
REQ-002 SHALL have parameter CW, default 8: width of the age, width and violation counters.
REQ-003 SHALL have parameter SETUP_CYC, default 2: minimum samples between a data edge and a later ref_ev.
REQ-004 SHALL have parameter HOLD_CYC, default 2: number of samples after ref_ev during which data must be stable.
REQ-005 SHALL have parameter WIDTH_CYC, default 3: minimum high-pulse length of data, in samples.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-008 SHALL have port ref_ev  input  1  reference event strobe; the sampled-clock edge being checked against.
REQ-009 SHALL have port data  input  NCH  checked data signals, one per channel.
REQ-010 SHALL have port cond  input  NCH  per-channel check enable; a check is armed only when its cond bit is 1 at ref_ev.
REQ-011 SHALL have port clr  input  1  synchronous clear of notifier and violation count.
REQ-012 SHALL have port viol_setup  output  NCH  one-cycle setup-violation pulse per channel.
REQ-013 SHALL have port viol_hold  output  NCH  one-cycle hold-violation pulse per channel.
REQ-014 SHALL have port viol_width  output  NCH  one-cycle width-violation pulse per channel.
REQ-015 SHALL have port notifier  output  NCH  per-channel register that toggles on every violating cycle.
REQ-016 SHALL have port viol_cnt  output  CW  saturating count of violating cycles summed over all channels.

Function
REQ-017 SHALL register data each cycle; edge[i] = data[i] XOR the previous registered data[i].
REQ-018 SHALL keep per-channel age: 0 in an edge cycle, otherwise previous age+1, saturating at 2^CW-1.
REQ-019 SHALL flag a setup violation when ref_ev=1, cond[i]=1 and age[i] < SETUP_CYC; an edge in the ref_ev cycle counts as age 0.
REQ-020 SHALL run a per-channel FSM with states IDLE and HOLD; IDLE->HOLD on ref_ev&cond[i] and load hold counter with HOLD_CYC.
REQ-021 SHALL, in HOLD, decrement the hold counter each cycle, flag a hold violation on any edge[i], and return to IDLE when it reaches 0.
REQ-022 SHALL treat an edge coincident with the arming ref_ev as setup only, never hold.
REQ-023 SHALL, on ref_ev&cond[i] while in HOLD, reload the counter to HOLD_CYC and stay in HOLD.
REQ-024 SHALL flag at most one hold violation per HOLD window and return to IDLE after flagging.
REQ-025 SHALL assert viol_* pulses in the cycle after the violating sample (latency 1), for exactly one cycle.
REQ-026 SHALL toggle notifier[i] once per cycle in which any viol_*[i] is asserted, regardless of how many kinds coincide.
REQ-027 SHALL add the number of channels with any violation that cycle to viol_cnt, saturating at 2^CW-1.
REQ-028 SHALL, on clr=1, zero notifier and viol_cnt in the next cycle, with clr taking priority over same-cycle increments; FSM and age state are unaffected.
REQ-029 SHALL treat HOLD_CYC=0 as hold check disabled (FSM never leaves IDLE) and SETUP_CYC=0 as setup check disabled.

Reset
REQ-030 SHALL, when rst=0 at a clock edge, set all viol_* to 0, notifier to 0, viol_cnt to 0, every FSM to IDLE, and every age to 2^CW-1.
REQ-031 SHALL load the registered data from the data inputs during reset, so that no edge is reported on the first cycle after reset.
REQ-032 SHALL abandon an open HOLD window on reset without flagging.

Configuration
REQ-033 SHALL implement the width check only when the macro TIMING_CHECK_WIDTH_EN is defined.
REQ-034 SHALL, with the macro defined, count high samples per channel (saturating) and flag a width violation on a falling edge when the count is below WIDTH_CYC.
REQ-035 SHALL, without the macro defined, tie viol_width to 0 and include no width counters.

Verification
REQ-036 SHALL pass this scenario: data[0] rises at cycle 10, ref_ev with cond=1 at cycle 11 -> viol_setup[0]=1 at cycle 12, notifier[0]=1, viol_cnt=1.
REQ-037 SHALL pass this scenario: ref_ev at cycle 20, data[1] toggles at cycle 22 -> viol_hold[1]=1 at cycle 23; a second toggle at cycle 23 -> no further pulse.
REQ-038 SHALL pass this scenario: ref_ev with cond[2]=0 and data[2] toggling in the same cycle -> no violations, notifier unchanged.
REQ-039 SHALL pass this scenario: with the macro defined, data[3] high for 2 samples -> viol_width[3]=1 one cycle after the fall; high for 3 samples -> none.
REQ-040 SHALL pass this scenario: setup and hold violations on channels 0 and 1 in the same cycle, viol_cnt=254, CW=8 -> viol_cnt=255 and stays there; clr -> 0.
REQ-041 SHALL pass this scenario: rst=0 asserted mid HOLD window, then a toggle in the following cycle -> no hold pulse, all outputs 0.
